// File: rtl/lc3b_types.sv
// Shared LC-3b types for the fetch-side predictor.
// Contents: lc3b_word, the 2-bit branch history counter type with its
// four named states, and bht_next(), the saturating counter update.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_bht_ctr;

    localparam lc3b_bht_ctr BHT_STRONG_NT = 2'b00;
    localparam lc3b_bht_ctr BHT_WEAK_NT   = 2'b01;
    localparam lc3b_bht_ctr BHT_WEAK_T    = 2'b10;
    localparam lc3b_bht_ctr BHT_STRONG_T  = 2'b11;

    // Saturating update: a taken branch moves toward STRONG_T and a
    // not-taken branch moves toward STRONG_NT. Both ends hold.
    function automatic lc3b_bht_ctr bht_next(input lc3b_bht_ctr ctr, input logic taken);
        lc3b_bht_ctr nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != BHT_STRONG_T) nxt = ctr + 2'd1;
        end else begin
            if (ctr != BHT_STRONG_NT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btb_array.sv
// BTB storage: per-entry valid, tag, target and 2-bit counter.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   rd_idx/rd_tag         : fetch lookup -> rd_hit, rd_ctr, rd_target (combinational)
//   wb_idx/wb_tag         : writeback lookup -> wb_hit, wb_ctr, wb_rd_target (combinational)
//   wr_en/wr_tag/wr_target/wr_ctr : synchronous write at wb_idx; it also sets valid
// On reset only the valid bits and counters are cleared, and any write in
// that cycle is dropped. Tags and targets are gated by valid, so they
// are never reset.
module btb_array
    import lc3b_types::*;
#(
    parameter int ENTRIES  = 16,
    parameter int IDX_BITS = $clog2(ENTRIES),
    parameter int TAG_BITS = 15 - IDX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    input  logic [TAG_BITS-1:0] rd_tag,
    output logic                rd_hit,
    output lc3b_bht_ctr         rd_ctr,
    output lc3b_word            rd_target,
    input  logic [IDX_BITS-1:0] wb_idx,
    input  logic [TAG_BITS-1:0] wb_tag,
    output logic                wb_hit,
    output lc3b_bht_ctr         wb_ctr,
    output lc3b_word            wb_rd_target,
    input  logic                wr_en,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  lc3b_word            wr_target,
    input  lc3b_bht_ctr         wr_ctr
);

    logic [ENTRIES-1:0]                valid_q, valid_d;
    lc3b_bht_ctr [ENTRIES-1:0]         ctr_q, ctr_d;
    logic [ENTRIES-1:0][TAG_BITS-1:0]  tag_q, tag_d;
    lc3b_word [ENTRIES-1:0]            target_q, target_d;

    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (wr_en) begin
            valid_d[wb_idx]  = 1'b1;
            ctr_d[wb_idx]    = wr_ctr;
            tag_d[wb_idx]    = wr_tag;
            target_d[wb_idx] = wr_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{BHT_WEAK_NT}};
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // A write during reset can land in tag/target. That is harmless
    // because valid is cleared in the same cycle.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign rd_hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_ctr       = ctr_q[rd_idx];
    assign rd_target    = target_q[rd_idx];

    assign wb_hit       = valid_q[wb_idx] && (tag_q[wb_idx] == wb_tag);
    assign wb_ctr       = ctr_q[wb_idx];
    assign wb_rd_target = target_q[wb_idx];

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit counter per entry.
// Ports:
//   clk, reset                   : clock and synchronous active-high reset
//   fetch_pc, load_decode,
//   flush_decode                 : fetch lookup and decode register control
//   decode_btb_hit/pred/target   : registered prediction for the decode stage
//   wb_valid, wb_pc, wb_taken,
//   wb_target                    : resolved branch used for training
//   wb_hit                       : combinational hit of wb_pc on the current table
// Address split: index = pc[IDX_BITS:1] and tag = pc[15:IDX_BITS+1].
// There is no fetch/update bypass, so a same-cycle lookup sees the
// pre-update table.
module branch_target_buffer
    import lc3b_types::*;
#(
    parameter int          ENTRIES        = 16,
    parameter lc3b_bht_ctr CTR_INIT_TAKEN = BHT_WEAK_T
) (
    input  logic     clk,
    input  logic     reset,
    input  lc3b_word fetch_pc,
    input  logic     load_decode,
    input  logic     flush_decode,
    output logic     decode_btb_hit,
    output logic     decode_pred,
    output lc3b_word decode_target,
    input  logic     wb_valid,
    input  lc3b_word wb_pc,
    input  logic     wb_taken,
    input  lc3b_word wb_target,
    output logic     wb_hit
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 15 - IDX_BITS;

    logic                rd_hit;
    lc3b_bht_ctr         rd_ctr;
    lc3b_word            rd_target;
    logic                wb_hit_int;
    lc3b_bht_ctr         wb_ctr;
    lc3b_word            wb_old_target;
    logic                wr_en;
    lc3b_bht_ctr         wr_ctr;
    lc3b_word            wr_target;

    // pc[0] is never used because instructions are word aligned.
    logic unused_pc_lsb;
    assign unused_pc_lsb = fetch_pc[0] ^ wb_pc[0];

    btb_array #(
        .ENTRIES  (ENTRIES),
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .rd_idx       (fetch_pc[IDX_BITS:1]),
        .rd_tag       (fetch_pc[15:IDX_BITS+1]),
        .rd_hit       (rd_hit),
        .rd_ctr       (rd_ctr),
        .rd_target    (rd_target),
        .wb_idx       (wb_pc[IDX_BITS:1]),
        .wb_tag       (wb_pc[15:IDX_BITS+1]),
        .wb_hit       (wb_hit_int),
        .wb_ctr       (wb_ctr),
        .wb_rd_target (wb_old_target),
        .wr_en        (wr_en),
        .wr_tag       (wb_pc[15:IDX_BITS+1]),
        .wr_target    (wr_target),
        .wr_ctr       (wr_ctr)
    );

    assign wb_hit = wb_hit_int;

    // Training policy. A hit trains the counter, and only a taken branch
    // refreshes the target. A taken miss allocates and evicts any alias.
    // A not-taken miss leaves the table unchanged.
    always_comb begin
        wr_en     = wb_valid && (wb_hit_int || wb_taken);
        wr_ctr    = wb_hit_int ? bht_next(wb_ctr, wb_taken) : CTR_INIT_TAKEN;
        wr_target = wb_taken ? wb_target : wb_old_target;
    end

    // Decode-stage prediction register.
    logic     dec_hit_q, dec_hit_d;
    logic     dec_pred_q, dec_pred_d;
    lc3b_word dec_target_q, dec_target_d;

    always_comb begin
        dec_hit_d    = dec_hit_q;
        dec_pred_d   = dec_pred_q;
        dec_target_d = dec_target_q;
        if (flush_decode) begin
            dec_hit_d    = 1'b0;
            dec_pred_d   = 1'b0;
            dec_target_d = '0;
        end else if (load_decode) begin
            dec_hit_d    = rd_hit;
            dec_pred_d   = rd_hit & rd_ctr[1];
            dec_target_d = rd_hit ? rd_target : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_hit_q    <= 1'b0;
            dec_pred_q   <= 1'b0;
            dec_target_q <= '0;
        end else begin
            dec_hit_q    <= dec_hit_d;
            dec_pred_q   <= dec_pred_d;
            dec_target_q <= dec_target_d;
        end
    end

    assign decode_btb_hit = dec_hit_q;
    assign decode_pred    = dec_pred_q;
    assign decode_target  = dec_target_q;

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Fetch-side branch predictor feeding the PC input selector. It is a direct-mapped BTB with one 2-bit saturating counter per entry. It is looked up with the fetch PC, and the result is registered into the decode stage as decode_btb_hit / decode_pred / decode_target. The entry is trained at writeback with the resolved branch outcome, which closes the loop with the selector's wb_btb_hit / wb_pred / wb_branch_enable inputs.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, minimum 2
IDX_BITS, $clog2(ENTRIES), index width; derived, never overridden
CTR_INIT_TAKEN, 2'b10, counter value written on allocation (weakly taken)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
fetch_pc  input  16  PC of the instruction being fetched (lc3b_word)
load_decode  input  1  advance fetch->decode prediction register; 0 = stall
flush_decode  input  1  squash decode prediction register (mispredict/trap redirect)
decode_btb_hit  output  1  registered: valid tag match for the decode-stage instruction
decode_pred  output  1  registered: counter MSB (1 = predict taken); 0 when not hit
decode_target  output  16  registered: predicted target; 16'h0000 when not hit
wb_valid  input  1  a control-flow instruction is resolving in writeback
wb_pc  input  16  PC of the resolving branch
wb_taken  input  1  resolved direction (branch_enable)
wb_target  input  16  resolved target address
wb_hit  output  1  combinational: wb_pc currently hits in the table

Behaviour:
- Address split: index = pc[IDX_BITS:1]; tag = pc[15:IDX_BITS+1]; pc[0] is ignored.
- Per entry: valid bit, tag, 16-bit target, 2-bit counter.
- Lookup is combinational on fetch_pc against registered table state. hit = valid && tag equal.
- Decode register, evaluated on each clk edge, in priority order: reset > flush_decode > load_decode > hold.
  - flush or reset: decode_btb_hit=0, decode_pred=0, decode_target=0.
  - load_decode=1: capture hit, hit&ctr[1], and hit?target:0.
  - load_decode=0: hold all three outputs.
- Latency: fetch_pc in cycle N produces the decode outputs in cycle N+1.
- Update happens on the clk edge with wb_valid=1 and reset=0:
  - wb_hit=1: counter saturating increment if wb_taken, else saturating decrement (11 stays 11, 00 stays 00). Target is rewritten with wb_target only if wb_taken.
  - wb_hit=0 and wb_taken=1: allocate the entry. Set valid=1, write tag, target=wb_target, ctr=CTR_INIT_TAKEN. This replaces any aliasing entry.
  - wb_hit=0 and wb_taken=0: no change. Not-taken branches are never allocated.
- Lookup and update in the same cycle to the same index: there is no bypass. The lookup sees pre-update state, and the update is visible from the next cycle.
- wb_hit is computed against current table state, not against the fetch-time snapshot.
- Reset: all valid bits cleared, all counters = 2'b01, decode outputs = 0. Tag and target arrays are not reset.
- Reset asserted during an update: the update is dropped and reset wins.

Decomposition:
- The lc3b_types package gains:
  - typedef lc3b_bht_ctr (logic [1:0])
  - constants BHT_STRONG_NT=2'b00, BHT_WEAK_NT=2'b01, BHT_WEAK_T=2'b10, BHT_STRONG_T=2'b11
  - function bht_next(ctr, taken) for saturating update
- One sub-module, btb_array: the valid/tag/target/counter storage with one combinational read port (fetch) and one combinational-read + synchronous-write port (writeback).
- The top level holds the decode register and the update policy.

Test Plan:
1. Reset, then fetch_pc=16'h3000 with load_decode=1 -> next cycle decode_btb_hit=0, decode_pred=0, decode_target=16'h0000.
2. wb_valid=1, wb_pc=16'h3004, wb_taken=1, wb_target=16'h3010 -> following cycle, fetch 16'h3004 with load_decode=1 gives decode_btb_hit=1, decode_pred=1, decode_target=16'h3010 one cycle later.
3. Three not-taken updates on 16'h3004 -> counter 10->01->00->00. Lookup gives hit=1, pred=0, target unchanged at 16'h3010. Then two taken updates -> 01->10, pred=1.
4. Alias: 16'h3024 shares index 2 with 16'h3004. Lookup 16'h3024 -> miss. A taken update to 16'h3024 (target 16'h3100) replaces the entry, and 16'h3004 then misses.
5. With a hit on fetch, load_decode=0 for 2 cycles -> outputs hold. flush_decode=1 together with load_decode=1 -> outputs all 0 next cycle.
6. Same-cycle fetch and allocating update to 16'h3004 -> that fetch's decode_btb_hit=0, and the next fetch of 16'h3004 hits. reset=1 together with wb_valid=1 -> no allocation, table empty afterward.
